md5_search_ctrl: RTL and testbench
==================================

Name: md5_search_ctrl

Overview:
Parametrised brute-force search controller for the MD5 engine. Issues candidate words over a programmable range to LANES parallel hash pipelines and compares returned hashes against a target. Latches the first matching candidate and reports done once the last issued candidate has drained out of the pipelines. Sits between the board-level debouncers/display selector and the hash pipelines.

Parameters:
LANES, 2, number of parallel hash pipelines fed per cycle (1..8)
CNT_W, 32, candidate width in bits
HASH_W, 128, hash width in bits
PIPE_LAT, 64, pipeline latency in cycles from cand_valid to hash_valid

Ports:
CLK  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, loads range and begins search
stop  in  1  one-cycle pulse, aborts issue and drains
enable  in  1  level; 1 = free run, 0 = pause
step  in  1  one-cycle pulse; issues one group while paused
range_lo  in  CNT_W  first candidate, sampled on start
range_hi  in  CNT_W  last candidate (inclusive), sampled on start
target_hash  in  HASH_W  target, sampled on start
cand_out  out  LANES*CNT_W  candidates to pipelines, lane i at [i*CNT_W +: CNT_W]
cand_valid  out  LANES  per-lane issue valid
hash_in  in  LANES*HASH_W  pipeline hash outputs
hash_cand_in  in  LANES*CNT_W  candidate carried through each pipeline
hash_valid  in  LANES  per-lane output valid
running  out  1  high in RUN or PAUSE
done  out  1  high in DONE
found  out  1  sticky match flag
found_cand  out  CNT_W  candidate that matched
found_lane  out  3  lane that matched
tested  out  CNT_W  number of candidates issued

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; counter 0.
- States: IDLE, RUN, PAUSE, DRAIN, DONE.
- IDLE/DONE + start: latch range_lo/range_hi/target; counter=range_lo; clear found, found_cand, found_lane, tested; go RUN (PAUSE if enable=0). start ignored in RUN/PAUSE/DRAIN.
- start with range_lo > range_hi: go directly to DONE next cycle; tested=0, no issue.
- RUN: each cycle, lane i gets counter+i; cand_valid[i]=1 iff counter+i <= range_hi, evaluated at CNT_W+1 bits (no wrap). counter += LANES; tested += popcount(cand_valid). Group containing range_hi is last: go DRAIN.
- enable=0 in RUN -> PAUSE next cycle; enable=1 in PAUSE -> RUN. PAUSE: cand_valid=0 except cycle after a step pulse, which issues exactly one group (same rules as RUN); step in RUN ignored.
- stop in RUN/PAUSE: no further issue, go DRAIN; stop elsewhere ignored.
- DRAIN: cand_valid=0; drain counter loads PIPE_LAT on entry, decrements each cycle; at 0 -> DONE. Compares continue during DRAIN.
- range_hi = 2^CNT_W-1: last candidate issued, counter may wrap internally but no further valid issue.
- Compare: registered, 1-cycle latency: hash_valid[i] && hash_in lane i == target sets found next cycle, captures hash_cand_in lane i and i. Simultaneous multi-lane match: lowest lane wins. found sticky; later matches ignored until next start.
- Compare active in RUN, PAUSE, DRAIN only; matches in IDLE/DONE ignored.
- done stays high until start or reset. reset_n mid-search returns to IDLE asynchronously; in-flight pipeline results are then ignored.

Optional Feature:
STOP_ON_FOUND_EN: when defined, the cycle found rises in RUN/PAUSE the controller stops issue and enters DRAIN (tested reflects only issued candidates). When undefined, search continues to range_hi; found remains sticky with first match.

Test Plan:
- LANES=2, range 0..7, target = MD5(00000002)=f11177d2ec63d995fb4ac628e0d782df, enable=1 -> 4 issue cycles, found=1, found_cand=2, found_lane=0, tested=8, done PIPE_LAT+~1 cycles after last issue.
- range 5..5 -> one group, cand_valid=01, tested=1, done; target absent -> found=0.
- enable=0 after start, three step pulses, range 0..15 -> exactly 3 groups issued, tested=6, running=1, done=0.
- range_lo=0xFFFFFFFE, range_hi=0xFFFFFFFF, LANES=2 -> one group, tested=2, no further valid, done.
- Two lanes matching same cycle (model drives identical hash) -> found_lane=0; range_lo=9, range_hi=3 -> DONE, tested=0.
- reset_n pulled low mid-RUN -> all outputs 0 immediately; with STOP_ON_FOUND_EN, match at cand 2 in range 0..1000 -> tested <= 2+2*(PIPE_LAT+2), done.

Source files
------------

// File: rtl/md5_search_ctrl.sv
// Brute-force search controller: issues LANES candidates per cycle over a
// range, compares returned hashes to a target. Optional macro: STOP_ON_FOUND_EN.
module md5_search_ctrl #(
  parameter int LANES    = 2,
  parameter int CNT_W    = 32,
  parameter int HASH_W   = 128,
  parameter int PIPE_LAT = 64
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      enable,
  input  logic                      step,
  input  logic [CNT_W-1:0]          range_lo,
  input  logic [CNT_W-1:0]          range_hi,
  input  logic [HASH_W-1:0]         target_hash,
  output logic [LANES*CNT_W-1:0]    cand_out,
  output logic [LANES-1:0]          cand_valid,
  input  logic [LANES*HASH_W-1:0]   hash_in,
  input  logic [LANES*CNT_W-1:0]    hash_cand_in,
  input  logic [LANES-1:0]          hash_valid,
  output logic                      running,
  output logic                      done,
  output logic                      found,
  output logic [CNT_W-1:0]          found_cand,
  output logic [2:0]                found_lane,
  output logic [CNT_W-1:0]          tested
);

  localparam int CW1 = CNT_W + 1;
  localparam int DW  = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [CNT_W-1:0]    hi_q, hi_d;
  logic [HASH_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]    tested_q, tested_d;
  logic                found_q, found_d;
  logic [CNT_W-1:0]    found_cand_q, found_cand_d;
  logic [2:0]          found_lane_q, found_lane_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                step_q, step_d;

  logic                issue;
  logic                last_group;
  logic                stop_found;
  logic [CNT_W-1:0]    issue_cnt;
  logic                hit;
  logic [CNT_W-1:0]    hit_cand;
  logic [2:0]          hit_lane;

  // Lane limits are compared at CNT_W+1 bits so a range ending at the top
  // of the counter space never lets wrapped candidates through.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves a latch.
    issue      = 1'b0;
    cand_valid = '0;
    cand_out   = '0;
    issue_cnt  = '0;
    stop_found = 1'b0;
`ifdef STOP_ON_FOUND_EN
    stop_found = found_q;
`endif
    if (state_q == S_RUN || (state_q == S_PAUSE && step_q)) begin
      issue = !stop && !stop_found;
    end
    for (int i = 0; i < LANES; i++) begin
      cand_valid[i] = issue && (({1'b0, counter_q} + CW1'(i)) <= {1'b0, hi_q});
      cand_out[i*CNT_W +: CNT_W] = issue ? (counter_q + CNT_W'(i)) : '0;
      issue_cnt = issue_cnt + CNT_W'(cand_valid[i]);
    end
    last_group = ({1'b0, counter_q} + CW1'(LANES - 1)) >= {1'b0, hi_q};
  end

  // Scan from the top lane down so the lowest matching lane wins.
  always_comb begin
    hit      = 1'b0;
    hit_cand = '0;
    hit_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hash_valid[i] && hash_in[i*HASH_W +: HASH_W] == target_q) begin
        hit      = 1'b1;
        hit_cand = hash_cand_in[i*CNT_W +: CNT_W];
        hit_lane = 3'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    hi_d         = hi_q;
    target_d     = target_q;
    tested_d     = tested_q;
    found_d      = found_q;
    found_cand_d = found_cand_q;
    found_lane_d = found_lane_q;
    drain_d      = drain_q;
    step_d       = (state_q == S_PAUSE) && step;

    if ((state_q == S_RUN || state_q == S_PAUSE || state_q == S_DRAIN) &&
        hit && !found_q) begin
      found_d      = 1'b1;
      found_cand_d = hit_cand;
      found_lane_d = hit_lane;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          hi_d         = range_hi;
          target_d     = target_hash;
          counter_d    = range_lo;
          tested_d     = '0;
          found_d      = 1'b0;
          found_cand_d = '0;
          found_lane_d = '0;
          if (range_lo > range_hi) state_d = S_DONE;
          else                     state_d = enable ? S_RUN : S_PAUSE;
        end
      end
      S_RUN, S_PAUSE: begin
        if (issue) begin
          counter_d = counter_q + CNT_W'(LANES);
          tested_d  = tested_q + issue_cnt;
        end
        if (stop || stop_found || (issue && last_group)) begin
          state_d = S_DRAIN;
          drain_d = DW'(PIPE_LAT);
        end else begin
          state_d = enable ? S_RUN : S_PAUSE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      counter_q    <= '0;
      hi_q         <= '0;
      target_q     <= '0;
      tested_q     <= '0;
      found_q      <= 1'b0;
      found_cand_q <= '0;
      found_lane_q <= '0;
      drain_q      <= '0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      hi_q         <= hi_d;
      target_q     <= target_d;
      tested_q     <= tested_d;
      found_q      <= found_d;
      found_cand_q <= found_cand_d;
      found_lane_q <= found_lane_d;
      drain_q      <= drain_d;
      step_q       <= step_d;
    end
  end

  assign running    = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done       = (state_q == S_DONE);
  assign found      = found_q;
  assign found_cand = found_cand_q;
  assign found_lane = found_lane_q;
  assign tested     = tested_q;

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl: pipeline model, transaction-level reference
// model checked every cycle, directed cases plus randomized searches.
module tb_md5_search_ctrl;

  localparam int LANES    = 2;
  localparam int CNT_W    = 32;
  localparam int HASH_W   = 128;
  localparam int PIPE_LAT = 64;
  localparam logic [127:0] MD5_2    = 128'hf11177d2ec63d995fb4ac628e0d782df;
  localparam logic [127:0] DUP_HASH = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
`ifdef STOP_ON_FOUND_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif

  logic                    CLK, reset_n, start, stop, enable, step;
  logic [CNT_W-1:0]        range_lo, range_hi;
  logic [HASH_W-1:0]       target_hash;
  logic [LANES*CNT_W-1:0]  cand_out;
  logic [LANES-1:0]        cand_valid;
  logic [LANES*HASH_W-1:0] hash_in;
  logic [LANES*CNT_W-1:0]  hash_cand_in;
  logic [LANES-1:0]        hash_valid;
  logic                    running, done, found;
  logic [CNT_W-1:0]        found_cand, tested;
  logic [2:0]              found_lane;

  md5_search_ctrl #(.LANES(LANES), .CNT_W(CNT_W), .HASH_W(HASH_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .stop(stop), .enable(enable), .step(step),
    .range_lo(range_lo), .range_hi(range_hi), .target_hash(target_hash),
    .cand_out(cand_out), .cand_valid(cand_valid), .hash_in(hash_in),
    .hash_cand_in(hash_cand_in), .hash_valid(hash_valid), .running(running), .done(done),
    .found(found), .found_cand(found_cand), .found_lane(found_lane), .tested(tested)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit dup_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in hash: candidate 2 carries its real MD5, everything else is unique filler.
  function automatic logic [127:0] hash_of(input logic [31:0] c);
    if (dup_mode && (c == 32'd4 || c == 32'd5)) return DUP_HASH;
    if (c == 32'd2) return MD5_2;
    return {c ^ 32'h1234_5678, ~c, c * 32'h9E37_79B9, c};
  endfunction

  // Pipeline model: entry k holds what was issued k cycles ago.
  logic [LANES-1:0]       pv [0:PIPE_LAT];
  logic [LANES*CNT_W-1:0] pc [0:PIPE_LAT];

  typedef enum {M_IDLE, M_ACTIVE, M_DRAIN, M_DONE} mphase_e;
  mphase_e          m_phase;
  bit               m_paused, m_step, m_found;
  longint           m_next, m_hi, m_tested;
  logic [127:0]     m_target;
  logic [31:0]      m_fcand;
  int               m_flane, m_drain;

  bit                     e_iss, e_hit, e_step_nx;
  logic [LANES-1:0]       e_valid;
  logic [LANES*CNT_W-1:0] e_out;
  longint                 e_cnt;
  logic [31:0]            e_hcand;
  int                     e_hlane;

  task automatic model_reset();
    m_phase = M_IDLE; m_paused = 0; m_step = 0; m_found = 0;
    m_next = 0; m_hi = 0; m_tested = 0; m_target = '0; m_fcand = '0;
    m_flane = 0; m_drain = 0;
    for (int j = 0; j <= PIPE_LAT; j++) begin pv[j] = '0; pc[j] = '0; end
    hash_valid = '0; hash_in = '0; hash_cand_in = '0;
  endtask

  always @(negedge CLK) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      e_iss = (m_phase == M_ACTIVE) && (!m_paused || m_step) && !stop && !(SOF && m_found);
      e_valid = '0; e_out = '0; e_cnt = 0;
      for (int i = 0; i < LANES; i++) begin
        longint v;
        logic [63:0] v64;
        v = m_next + i;
        v64 = 64'(v);
        e_valid[i] = e_iss && (v <= m_hi);
        if (e_iss) e_out[i*CNT_W +: CNT_W] = v64[31:0];
        if (e_valid[i]) e_cnt++;
      end
      check("cand_valid", 128'(cand_valid), 128'(e_valid));
      check("cand_out", 128'(cand_out), 128'(e_out));
      check("running", 128'(running), 128'(m_phase == M_ACTIVE));
      check("done", 128'(done), 128'(m_phase == M_DONE));
      check("found", 128'(found), 128'(m_found));
      check("found_cand", 128'(found_cand), 128'(m_fcand));
      check("found_lane", 128'(found_lane), 128'(m_flane));
      check("tested", 128'(tested), 128'(m_tested[31:0]));

      for (int j = PIPE_LAT; j > 0; j--) begin pv[j] = pv[j-1]; pc[j] = pc[j-1]; end
      pv[0] = cand_valid; pc[0] = cand_out;
      hash_valid = pv[PIPE_LAT];
      hash_cand_in = pc[PIPE_LAT];
      for (int i = 0; i < LANES; i++)
        hash_in[i*HASH_W +: HASH_W] = hash_of(pc[PIPE_LAT][i*CNT_W +: CNT_W]);

      e_hit = 0; e_hcand = '0; e_hlane = 0;
      if ((m_phase == M_ACTIVE || m_phase == M_DRAIN) && !m_found) begin
        for (int i = 0; i < LANES; i++) begin
          if (!e_hit && pv[PIPE_LAT][i] &&
              hash_of(pc[PIPE_LAT][i*CNT_W +: CNT_W]) == m_target) begin
            e_hit = 1; e_hcand = pc[PIPE_LAT][i*CNT_W +: CNT_W]; e_hlane = i;
          end
        end
      end
      e_step_nx = (m_phase == M_ACTIVE) && m_paused && step;

      case (m_phase)
        M_IDLE, M_DONE: if (start) begin
          m_hi = longint'(range_hi); m_next = longint'(range_lo); m_target = target_hash;
          m_tested = 0; m_found = 0; m_fcand = '0; m_flane = 0;
          m_paused = !enable;
          m_phase = (range_lo > range_hi) ? M_DONE : M_ACTIVE;
        end
        M_ACTIVE: begin
          bit last;
          last = (m_next + LANES - 1) >= m_hi;
          if (e_iss) begin m_tested += e_cnt; m_next += LANES; end
          if (stop || (SOF && m_found) || (e_iss && last)) begin
            m_phase = M_DRAIN; m_drain = PIPE_LAT;
          end else begin
            m_paused = !enable;
          end
        end
        M_DRAIN: begin
          if (m_drain == 0) m_phase = M_DONE;
          else m_drain--;
        end
        default: ;
      endcase
      m_step = e_step_nx;
      if (e_hit) begin m_found = 1; m_fcand = e_hcand; m_flane = e_hlane; end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_search(input logic [31:0] lo, input logic [31:0] hi,
                              input logic [127:0] tgt, input bit en);
    range_lo = lo; range_hi = hi; target_hash = tgt; enable = en; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin tick(); n++; end
    check(name, 128'(done), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 0; stop = 0; enable = 1; step = 0;
    range_lo = '0; range_hi = '0; target_hash = '0;
    hash_valid = '0; hash_in = '0; hash_cand_in = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_running", 128'(running), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_tested", 128'(tested), 128'(0));
    check("rst_cand_out", 128'(cand_out), 128'(0));
    reset_n = 1'b1;
    tick();

    // Range 0..7, target is candidate 2.
    start_search(32'd0, 32'd7, MD5_2, 1'b1);
    check("t1_first_valid", 128'(cand_valid), 128'(2'b11));
    check("t1_first_cands", 128'(cand_out), 128'(64'h00000001_00000000));
    wait_done(300, "t1_done");
    check("t1_tested", 128'(tested), 128'(8));
    check("t1_found", 128'(found), 128'(1));
    check("t1_found_cand", 128'(found_cand), 128'(2));
    check("t1_found_lane", 128'(found_lane), 128'(0));

    // Single-candidate range, target absent.
    start_search(32'd5, 32'd5, MD5_2, 1'b1);
    check("t2_valid", 128'(cand_valid), 128'(2'b01));
    wait_done(300, "t2_done");
    check("t2_tested", 128'(tested), 128'(1));
    check("t2_found", 128'(found), 128'(0));

    // Paused start with three single steps.
    start_search(32'd0, 32'd15, MD5_2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0; tick(); tick();
    end
    check("t3_tested", 128'(tested), 128'(6));
    check("t3_running", 128'(running), 128'(1));
    check("t3_done", 128'(done), 128'(0));
    stop = 1'b1; tick(); stop = 1'b0;
    wait_done(300, "t3_drain_done");
    check("t3_found_cand", 128'(found_cand), 128'(2));
    enable = 1'b1;

    // Top of counter space.
    start_search(32'hFFFF_FFFE, 32'hFFFF_FFFF, MD5_2, 1'b1);
    check("t4_valid", 128'(cand_valid), 128'(2'b11));
    wait_done(300, "t4_done");
    check("t4_tested", 128'(tested), 128'(2));

    // Two lanes match in the same cycle: lane 0 wins.
    dup_mode = 1'b1;
    start_search(32'd0, 32'd7, DUP_HASH, 1'b1);
    wait_done(300, "t5_done");
    check("t5_found_lane", 128'(found_lane), 128'(0));
    check("t5_found_cand", 128'(found_cand), 128'(4));
    dup_mode = 1'b0;

    // Inverted range goes straight to DONE.
    start_search(32'd9, 32'd3, MD5_2, 1'b1);
    check("t6_done", 128'(done), 128'(1));
    check("t6_tested", 128'(tested), 128'(0));

    // Asynchronous reset mid-run.
    start_search(32'd0, 32'd1000, MD5_2, 1'b1);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("t7_valid", 128'(cand_valid), 128'(0));
    check("t7_running", 128'(running), 128'(0));
    check("t7_tested", 128'(tested), 128'(0));
    check("t7_cand_out", 128'(cand_out), 128'(0));
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Long range with an early match.
    start_search(32'd0, 32'd1000, MD5_2, 1'b1);
    wait_done(1500, "t8_done");
    check("t8_found_cand", 128'(found_cand), 128'(2));
`ifdef STOP_ON_FOUND_EN
    check("t8_tested_bound", 128'(tested <= 32'(2 + 2 * (PIPE_LAT + 2))), 128'(1));
`else
    check("t8_tested_all", 128'(tested), 128'(1001));
`endif

    // Randomized searches with pause/step/stop and ignored start pulses.
    for (int r = 0; r < 10; r++) begin
      logic [31:0] lo, hi, tc;
      longint span, top;
      lo = $urandom_range(0, 500);
      if ($urandom_range(0, 3) == 0) lo = 32'hFFFF_FFFF - $urandom_range(0, 10);
      span = $urandom_range(0, 30);
      top = longint'(lo) + span;
      hi = (top > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(top);
      if ($urandom_range(0, 7) == 0) hi = lo - 1;
      tc = lo + $urandom_range(0, 34);
      start_search(lo, hi, hash_of(tc), $urandom_range(0, 1) == 1);
      for (int n = 0; n < 1200 && done !== 1'b1; n++) begin
        enable = ($urandom_range(0, 3) != 0);
        step   = ($urandom_range(0, 2) == 0);
        stop   = ($urandom_range(0, 80) == 0);
        start  = running && ($urandom_range(0, 40) == 0);
        range_lo = $urandom; range_hi = $urandom;
        tick();
      end
      start = 0; step = 0; stop = 0; enable = 1;
      wait_done(200, "rand_done");
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
